// File: rtl/mainmem_zbt_param.sv
// ZBT-style pipelined synchronous main memory with byte writes, 4-beat bursts
// and late-write forwarding so reads always see earlier-issued writes.
module mainmem_zbt_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 17,
    parameter int READ_LAT   = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                  GCLK,
    input  logic                  nRESET,
    input  logic [ADDR_W-1:0]     MMA,
    input  logic                  MMnCS,
    input  logic                  MMADV,
    input  logic                  MMnWR,
    input  logic [DATA_W/8-1:0]   MMnBW,
    input  logic                  MMnLBO,
    input  logic [DATA_W-1:0]     MMDI,
    output logic [DATA_W-1:0]     MMDO,
    output logic                  MMDOE
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int BB    = $clog2(BURST_LEN);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] widx_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic          bst_active;
    logic          bst_wr;
    logic          bst_lbo;
    widx_t         bst_base;
    logic [BB-1:0] bst_cnt;

    logic          do_load;
    logic          do_adv;
    logic          cmd_lbo;
    widx_t         cmd_base;
    logic [BB-1:0] cmd_cnt;
    logic [BB-1:0] cmd_low;

    // Stage 0 is the command at this edge; stage k (k>=1) is pipe register k-1.
    logic          s_valid [READ_LAT+1];
    logic          s_wr    [READ_LAT+1];
    widx_t         s_addr  [READ_LAT+1];
    logic [NB-1:0] s_be    [READ_LAT+1];

    logic          p_valid [READ_LAT];
    logic          p_wr    [READ_LAT];
    widx_t         p_addr  [READ_LAT];
    logic [NB-1:0] p_be    [READ_LAT];

    logic [DATA_W-1:0] rd_data;
    logic              rd_hit;
    logic              unused_mma;

    assign unused_mma = ^{MMA[ADDR_W-1:LSB+DEPTH_LOG2], MMA[LSB-1:0]};

    always_comb begin
        do_load  = !MMnCS && !MMADV;
        do_adv   = !MMnCS && MMADV && bst_active;
        cmd_lbo  = do_load ? MMnLBO : bst_lbo;
        cmd_base = do_load ? MMA[LSB +: DEPTH_LOG2] : bst_base;
        cmd_cnt  = do_load ? '0 : bst_cnt + 1'b1;
        cmd_low  = cmd_lbo ? (cmd_base[BB-1:0] ^ cmd_cnt) : (cmd_base[BB-1:0] + cmd_cnt);

        s_valid[0]          = do_load || do_adv;
        s_wr[0]             = do_load ? !MMnWR : bst_wr;
        s_addr[0]           = cmd_base;
        s_addr[0][BB-1:0]   = cmd_low;
        s_be[0]             = ~MMnBW;
        for (int k = 1; k <= READ_LAT; k++) begin
            s_valid[k] = p_valid[k-1];
            s_wr[k]    = p_wr[k-1];
            s_addr[k]  = p_addr[k-1];
            s_be[k]    = p_be[k-1];
        end
    end

    always_ff @(posedge GCLK or negedge nRESET) begin
        if (!nRESET) begin
            bst_active <= 1'b0;
            bst_wr     <= 1'b0;
            bst_lbo    <= 1'b0;
            bst_base   <= '0;
            bst_cnt    <= '0;
        end else if (MMnCS) begin
            bst_active <= 1'b0;
        end else if (do_load) begin
            bst_active <= 1'b1;
            bst_wr     <= !MMnWR;
            bst_lbo    <= MMnLBO;
            bst_base   <= cmd_base;
            bst_cnt    <= '0;
        end else if (do_adv) begin
            bst_cnt    <= cmd_cnt;
        end
    end

    always_ff @(posedge GCLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int k = 0; k < READ_LAT; k++) begin
                p_valid[k] <= 1'b0;
                p_wr[k]    <= 1'b0;
                p_addr[k]  <= '0;
                p_be[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < READ_LAT; k++) begin
                p_valid[k] <= s_valid[k];
                p_wr[k]    <= s_wr[k];
                p_addr[k]  <= s_addr[k];
                p_be[k]    <= s_be[k];
            end
        end
    end

    // Late write: data arrives READ_LAT edges after its command and lands then.
    always_ff @(posedge GCLK) begin
        if (s_valid[READ_LAT] && s_wr[READ_LAT]) begin
            for (int i = 0; i < NB; i++) begin
                if (s_be[READ_LAT][i])
                    mem[s_addr[READ_LAT]][8*i +: 8] <= MMDI[8*i +: 8];
            end
        end
    end

    // Only the write landing on this same edge is not yet in the array.
    always_comb begin
        rd_data = mem[s_addr[READ_LAT-1]];
        rd_hit  = s_valid[READ_LAT-1] && !s_wr[READ_LAT-1];
        for (int i = 0; i < NB; i++) begin
            if (s_valid[READ_LAT] && s_wr[READ_LAT] && s_be[READ_LAT][i] &&
                (s_addr[READ_LAT] == s_addr[READ_LAT-1]))
                rd_data[8*i +: 8] = MMDI[8*i +: 8];
        end
    end

    always_ff @(posedge GCLK or negedge nRESET) begin
        if (!nRESET) begin
            MMDOE <= 1'b0;
            MMDO  <= '0;
        end else begin
            MMDOE <= rd_hit;
            MMDO  <= rd_hit ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_mainmem_zbt_param.sv
// Directed bench for mainmem_zbt_param: transaction model plus scoreboard of
// expected read data stamped with the cycle it must appear.
module tb_mainmem_zbt_param;

    localparam int RL = 2;

    logic        GCLK   = 1'b0;
    logic        nRESET = 1'b0;
    logic [31:0] MMA    = '0;
    logic        MMnCS  = 1'b1;
    logic        MMADV  = 1'b0;
    logic        MMnWR  = 1'b1;
    logic [3:0]  MMnBW  = 4'hF;
    logic        MMnLBO = 1'b0;
    logic [31:0] MMDI   = '0;
    logic [31:0] MMDO;
    logic        MMDOE;

    mainmem_zbt_param #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4), .READ_LAT(RL), .BURST_LEN(4)
    ) dut (
        .GCLK(GCLK), .nRESET(nRESET), .MMA(MMA), .MMnCS(MMnCS), .MMADV(MMADV),
        .MMnWR(MMnWR), .MMnBW(MMnBW), .MMnLBO(MMnLBO), .MMDI(MMDI),
        .MMDO(MMDO), .MMDOE(MMDOE)
    );

    always #5 GCLK = ~GCLK;

    int cyc = 0;
    always @(posedge GCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] di_sched [int];
    logic [31:0] mdl [16];

    logic       b_act = 1'b0;
    logic       b_wr  = 1'b0;
    logic       b_lbo = 1'b0;
    logic [3:0] b_s   = '0;
    int         b_c   = 0;

    task automatic check_out();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $error("FAIL %s: no read data seen at cycle %0d, expected MMDO=%h", e.tag, e.cyc, e.d);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            checks++;
            assert (MMDOE === 1'b1 && MMDO === e.d) else begin
                errors++;
                $error("FAIL %s: MMDOE=%b MMDO=%h, expected MMDOE=1 MMDO=%h", e.tag, MMDOE, MMDO, e.d);
            end
        end else begin
            checks++;
            assert (MMDOE === 1'b0 && MMDO === 32'h0) else begin
                errors++;
                $error("FAIL idle@%0d: MMDOE=%b MMDO=%h, expected MMDOE=0 MMDO=0", cyc, MMDOE, MMDO);
            end
        end
    endtask

    task automatic cmd(input logic cs_n, input logic adv, input logic wr_n, input logic [3:0] bw_n,
                       input logic lbo, input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic       beat;
        logic [3:0] w;
        int         low;
        beat = 1'b0;
        if (cs_n) begin
            b_act = 1'b0;
        end else if (!adv) begin
            b_act = 1'b1; b_wr = !wr_n; b_lbo = lbo; b_s = addr[5:2]; b_c = 0; beat = 1'b1;
        end else if (b_act) begin
            b_c = (b_c + 1) % 4; beat = 1'b1;
        end
        if (beat) begin
            low = b_lbo ? (int'(b_s[1:0]) ^ b_c) : ((int'(b_s[1:0]) + b_c) % 4);
            w   = {b_s[3:2], 2'(low)};
            if (b_wr) begin
                for (int i = 0; i < 4; i++)
                    if (!bw_n[i]) mdl[w][8*i +: 8] = data[8*i +: 8];
                di_sched[cyc + 1 + RL] = data;
            end else begin
                sb.push_back('{mdl[w], cyc + RL, tag});
            end
        end
        MMnCS = cs_n; MMADV = adv; MMnWR = wr_n; MMnBW = bw_n; MMnLBO = lbo; MMA = addr;
        MMDI  = di_sched.exists(cyc + 1) ? di_sched[cyc + 1] : 32'h0;
        @(negedge GCLK);
        check_out();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bw_n);
        cmd(1'b0, 1'b0, 1'b0, bw_n, 1'b0, addr, data, "wr");
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic lbo, input logic [31:0] data);
        cmd(1'b0, 1'b0, 1'b0, 4'h0, lbo, addr, data, "wrb");
    endtask

    task automatic wr_adv(input logic [31:0] data);
        cmd(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0, data, "wradv");
    endtask

    task automatic rd(input logic [31:0] addr, input logic lbo, input string tag);
        cmd(1'b0, 1'b0, 1'b1, 4'hF, lbo, addr, 32'h0, tag);
    endtask

    task automatic rd_adv(input string tag);
        cmd(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 32'h0, 32'h0, tag);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            cmd(1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 32'h0, 32'h0, "nop");
    endtask

    initial begin
        logic [31:0] old_w1;

        repeat (2) @(negedge GCLK);
        checks++;
        assert (MMDOE === 1'b0 && MMDO === 32'h0) else begin
            errors++;
            $error("FAIL reset_state: MMDOE=%b MMDO=%h, expected 0/0", MMDOE, MMDO);
        end
        nRESET = 1'b1;

        // single write, gap, read
        wr(32'h100, 32'hDEADBEEF, 4'h0);
        nop(3);
        rd(32'h100, 1'b0, "t2_read");
        nop(3);

        // byte lanes, then an all-lanes-masked write
        wr(32'h200, 32'h11223344, 4'h0);
        wr(32'h200, 32'hAABBCCDD, 4'b1010);
        rd(32'h200, 1'b0, "t3_lanes");
        wr(32'h200, 32'hFFFFFFFF, 4'hF);
        rd(32'h200, 1'b0, "t3_nobw");
        nop(3);

        // linear write burst, interleaved read burst from word 3
        wr_burst(32'h40C, 1'b0, 32'hA0A0A0A0);
        wr_adv(32'hB1B1B1B1);
        wr_adv(32'hC2C2C2C2);
        wr_adv(32'hD3D3D3D3);
        rd(32'h40C, 1'b1, "t4_w3");
        rd_adv("t4_w2");
        rd_adv("t4_w1");
        rd_adv("t4_w0");
        rd(32'h400, 1'b0, "t4_lin0");
        nop(3);

        // no-turnaround write/read/write/read
        wr(32'h300, 32'h5555AAAA, 4'h0);
        rd(32'h300, 1'b0, "t5_rd1");
        wr(32'h300, 32'h00000000, 4'h0);
        rd(32'h300, 1'b0, "t5_rd2");
        nop(3);

        // aliasing, and advance after deselect is a NOP
        wr(32'h40, 32'h12345678, 4'h0);
        nop(1);
        rd(32'h00, 1'b0, "t6_alias");
        nop(3);
        rd(32'h08, 1'b0, "t6_beat0");
        nop(1);
        rd_adv("t6_dead_adv");
        rd_adv("t6_dead_adv");
        nop(3);

        // reset mid read burst with a write pending
        old_w1 = mdl[1];
        rd(32'h108, 1'b0, "t1_r0");
        rd_adv("t1_r1");
        rd_adv("t1_r2");
        wr(32'h104, 32'h99999999, 4'h0);
        nRESET = 1'b0;
        #1;
        checks++;
        assert (MMDOE === 1'b0 && MMDO === 32'h0) else begin
            errors++;
            $error("FAIL t1_async: MMDOE=%b MMDO=%h, expected 0/0", MMDOE, MMDO);
        end
        mdl[1] = old_w1;
        sb.delete();
        b_act = 1'b0;
        MMnCS = 1'b1;
        repeat (3) @(negedge GCLK);
        nRESET = 1'b1;
        rd(32'h104, 1'b0, "t1_old");
        rd_adv("t1_adv");
        nop(4);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: %0d reads outstanding, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
